// File: rtl/iter_cmp_pkg.sv
// ---------------------------------------------------------------------------
// iter_cmp_pkg : shared types, comparison-mode encodings and result helpers
// for the iterative comparator.
// ---------------------------------------------------------------------------
`default_nettype none

package iter_cmp_pkg;

  // Controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Comparison-mode encodings. EQUAL/NOTEQUAL keep their historical codes;
  // new modes are appended after them so existing users are unaffected.
  localparam logic [3:0] CMPMode_EQUAL    = 4'd0;
  localparam logic [3:0] CMPMode_NOTEQUAL = 4'd1;
  localparam logic [3:0] CMPMode_PAL      = 4'd2;
  localparam logic [3:0] CMPMode_LT       = 4'd3;
  localparam logic [3:0] CMPMode_LTU      = 4'd4;
  localparam logic [3:0] CMPMode_GEZ      = 4'd5;
  localparam logic [3:0] CMPMode_GTZ      = 4'd6;
  localparam logic [3:0] CMPMode_LEZ      = 4'd7;
  localparam logic [3:0] CMPMode_LTZ      = 4'd8;

  // Modes that compare A against zero (B is replaced by zero at accept)
  function automatic logic mode_is_zero(input logic [3:0] mode);
    return (mode >= CMPMode_GEZ) && (mode <= CMPMode_LTZ);
  endfunction

  // Modes using two's-complement ordering (MSBs inverted before the scan)
  function automatic logic mode_is_signed(input logic [3:0] mode);
    return (mode == CMPMode_LT) || mode_is_zero(mode);
  endfunction

  // Final result from the accumulated scan flags; unused codes give 0
  function automatic logic cmp_result(input logic [3:0] mode,
                                      input logic       eq,
                                      input logic       lt,
                                      input logic       pal);
    logic r;
    case (mode)
      CMPMode_EQUAL:    r = eq;
      CMPMode_NOTEQUAL: r = ~eq;
      CMPMode_PAL:      r = pal;
      CMPMode_LT:       r = lt;
      CMPMode_LTU:      r = lt;
      CMPMode_GEZ:      r = ~lt;
      CMPMode_GTZ:      r = ~lt & ~eq;
      CMPMode_LEZ:      r = lt | eq;
      CMPMode_LTZ:      r = lt;
      default:          r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/iter_cmp_slice.sv
// ---------------------------------------------------------------------------
// cmp_slice : one CHUNK-bit step of the iterative comparator. Updates the
// MSB-first equal/less-than flags and the palindrome flag.
// ---------------------------------------------------------------------------
`default_nettype none

module cmp_slice #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,       // current chunk of A, MSB side
  input  logic [CHUNK-1:0] b,       // current chunk of B, MSB side
  input  logic [CHUNK-1:0] m,       // mirror chunk of A, LSB side
  input  logic             eq_in,
  input  logic             lt_in,
  input  logic             pal_in,
  output logic             eq_out,
  output logic             lt_out,
  output logic             pal_out
);

  logic [CHUNK-1:0] m_rev;

  // Bit-reverse the mirror chunk so it lines up with the MSB-side chunk
  always_comb begin
    m_rev = '0;
    for (int i = 0; i < CHUNK; i++) begin
      m_rev[i] = m[CHUNK-1-i];
    end
  end

  // Less-than is decided by the first differing chunk from the top
  always_comb begin
    eq_out  = eq_in & (a == b);
    lt_out  = lt_in | (eq_in & (a < b));
    pal_out = pal_in & (a == m_rev);
  end

endmodule

`default_nettype wire

// File: rtl/iter_cmp.sv
// ---------------------------------------------------------------------------
// iter_cmp : multi-cycle comparator examining CHUNK bits per cycle with a
// fixed latency of WIDTH/CHUNK cycles for every mode.
// WIDTH must be a multiple of CHUNK and CHUNK >= 1.
// ---------------------------------------------------------------------------
`default_nettype none

module iter_cmp
  import iter_cmp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset,      // asynchronous, active low
  input  logic             start,
  input  logic             flush,
  input  logic [3:0]       CMPMode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             cmp
);

  localparam int LAT = WIDTH / CHUNK;
  localparam int CW  = $clog2(LAT + 1);
  localparam logic [CW-1:0] LAST = CW'(LAT - 1);

  state_t state, state_nxt;
  logic   accept, finish, step;

  // Working copies: sh_a/sh_b shift left (MSB chunk first), sh_m shifts
  // right so its low chunk is the palindrome mirror of sh_a's top chunk.
  logic [WIDTH-1:0] sh_a, sh_b, sh_m;
  logic [3:0]       mode_q;
  logic             eq_q, lt_q, pal_q;
  logic [CW-1:0]    cnt;
  logic             cmp_q;

  logic [WIDTH-1:0] a_load, b_load, msb_flip;
  logic             eq_nx, lt_nx, pal_nx;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and status outputs; flush overrides everything else
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == LAST) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) begin
      state_nxt = IDLE;
      accept    = 1'b0;
      finish    = 1'b0;
    end
  end

  assign step = busy & ~flush;

  // Operand preparation at accept: zero modes ignore B, signed modes flip MSBs
  always_comb begin
    msb_flip = mode_is_signed(CMPMode) ? (WIDTH'(1) << (WIDTH - 1)) : '0;
    b_load   = mode_is_zero(CMPMode) ? '0 : B;
    a_load   = A ^ msb_flip;
    b_load   = b_load ^ msb_flip;
  end

  cmp_slice #(
    .CHUNK (CHUNK)
  ) u_slice (
    .a       (sh_a[WIDTH-1 -: CHUNK]),
    .b       (sh_b[WIDTH-1 -: CHUNK]),
    .m       (sh_m[CHUNK-1:0]),
    .eq_in   (eq_q),
    .lt_in   (lt_q),
    .pal_in  (pal_q),
    .eq_out  (eq_nx),
    .lt_out  (lt_nx),
    .pal_out (pal_nx)
  );

  // Datapath: latch at accept, scan one chunk per RUN cycle, publish at the end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh_a   <= '0;
      sh_b   <= '0;
      sh_m   <= '0;
      mode_q <= '0;
      eq_q   <= 1'b0;
      lt_q   <= 1'b0;
      pal_q  <= 1'b0;
      cnt    <= '0;
      cmp_q  <= 1'b0;
    end else if (accept) begin
      sh_a   <= a_load;
      sh_b   <= b_load;
      sh_m   <= A;
      mode_q <= CMPMode;
      eq_q   <= 1'b1;
      lt_q   <= 1'b0;
      pal_q  <= 1'b1;
      cnt    <= '0;
    end else if (step) begin
      sh_a  <= sh_a << CHUNK;
      sh_b  <= sh_b << CHUNK;
      sh_m  <= sh_m >> CHUNK;
      eq_q  <= eq_nx;
      lt_q  <= lt_nx;
      pal_q <= pal_nx;
      cnt   <= cnt + CW'(1);
      if (finish) cmp_q <= cmp_result(mode_q, eq_nx, lt_nx, pal_nx);
    end
  end

  assign cmp = cmp_q;

endmodule

`default_nettype wire

// File: tb/tb_iter_cmp.sv
// ---------------------------------------------------------------------------
// tb_iter_cmp : self-checking bench for iter_cmp (32/4 and 16/8 instances)
// against an arithmetic reference model.
// ---------------------------------------------------------------------------
`default_nettype none

module tb_iter_cmp;

  logic        clk = 1'b0;
  logic        reset = 1'b0;

  logic        start32 = 0, flush32 = 0;
  logic [3:0]  mode32 = 0;
  logic [31:0] a32 = 0, b32 = 0;
  logic        busy32, done32, cmp32;

  logic        start16 = 0, flush16 = 0;
  logic [3:0]  mode16 = 0;
  logic [15:0] a16 = 0, b16 = 0;
  logic        busy16, done16, cmp16;

  logic        sel16 = 0;
  logic        ob_busy, ob_done, ob_cmp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  iter_cmp #(.WIDTH(32), .CHUNK(4)) dut (
    .clk(clk), .reset(reset), .start(start32), .flush(flush32),
    .CMPMode(mode32), .A(a32), .B(b32),
    .busy(busy32), .done(done32), .cmp(cmp32)
  );

  iter_cmp #(.WIDTH(16), .CHUNK(8)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .flush(flush16),
    .CMPMode(mode16), .A(a16), .B(b16),
    .busy(busy16), .done(done16), .cmp(cmp16)
  );

  assign ob_busy = sel16 ? busy16 : busy32;
  assign ob_done = sel16 ? done16 : done32;
  assign ob_cmp  = sel16 ? cmp16  : cmp32;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on w-bit operands
  function automatic logic ref_cmp(input logic [3:0] mode, input logic [31:0] a_in,
                                   input logic [31:0] b_in, input int w);
    longint mask = (longint'(1) << w) - 1;
    longint ua = longint'(a_in) & mask;
    longint ub = longint'(b_in) & mask;
    longint sa = (ua >= (longint'(1) << (w - 1))) ? ua - (longint'(1) << w) : ua;
    longint sb = (ub >= (longint'(1) << (w - 1))) ? ub - (longint'(1) << w) : ub;
    logic r;
    case (mode)
      4'd0: r = (ua == ub);
      4'd1: r = (ua != ub);
      4'd2: begin
        r = 1'b1;
        for (int i = 0; i < w; i++) if (a_in[i] != a_in[w-1-i]) r = 1'b0;
      end
      4'd3: r = (sa < sb);
      4'd4: r = (ua < ub);
      4'd5: r = (sa >= 0);
      4'd6: r = (sa > 0);
      4'd7: r = (sa <= 0);
      4'd8: r = (sa < 0);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  task automatic drive(input bit s16, input bit st, input logic [3:0] m,
                       input logic [31:0] a, input logic [31:0] b);
    if (s16) begin
      start16 = st; mode16 = m; a16 = a[15:0]; b16 = b[15:0];
    end else begin
      start32 = st; mode32 = m; a32 = a; b32 = b;
    end
  endtask

  // Called at the negedge right after the accepting edge; bounded wait for done
  task automatic wait_done(output int n, output int bc);
    n = 0;
    bc = 0;
    while (!ob_done && n < 20) begin
      bc += int'(ob_busy);
      @(negedge clk);
      n++;
    end
  endtask

  task automatic do_cmp(input bit s16, input logic [3:0] m, input logic [31:0] a,
                        input logic [31:0] b, input string tag);
    int lat = s16 ? 2 : 8;
    logic exp = ref_cmp(m, a, b, s16 ? 16 : 32);
    int n, bc;
    sel16 = s16;
    @(negedge clk);
    drive(s16, 1'b1, m, a, b);
    @(negedge clk);
    drive(s16, 1'b0, m, a, b);
    wait_done(n, bc);
    check({tag, "_latency"}, n, lat);
    check({tag, "_busycycles"}, bc, lat);
    check({tag, "_busy_at_done"}, ob_busy, 1'b0);
    check({tag, "_cmp"}, ob_cmp, exp);
    @(negedge clk);
    check({tag, "_done_pulse"}, ob_done, 1'b0);
    check({tag, "_cmp_hold"}, ob_cmp, exp);
  endtask

  initial begin
    int n, bc, seen;
    logic [31:0] ra, rb;
    logic [3:0]  rm;
    bit          rs;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy32", busy32, 0);
    check("rst_done32", done32, 0);
    check("rst_cmp32",  cmp32,  0);
    check("rst_busy16", busy16, 0);
    check("rst_cmp16",  cmp16,  0);
    // Release mid-high phase so the next rising edge is the first after release
    @(posedge clk);
    #2 reset = 1'b1;

    // Directed 32/4
    do_cmp(0, 4'd0, 32'h1234_5678, 32'h1234_5678, "eq_same");
    do_cmp(0, 4'd0, 32'h1234_5678, 32'h1234_5679, "eq_diff");
    do_cmp(0, 4'd1, 32'h1234_5678, 32'h1234_5679, "ne_diff");
    do_cmp(0, 4'd2, 32'h8000_0001, 32'h0, "pal_8001");
    do_cmp(0, 4'd2, 32'h8000_0002, 32'h0, "pal_8002");
    do_cmp(0, 4'd2, 32'hF00F_F00F, 32'h0, "pal_f00f");
    do_cmp(0, 4'd3, 32'hFFFF_FFFF, 32'h0000_0001, "lt_neg");
    do_cmp(0, 4'd4, 32'hFFFF_FFFF, 32'h0000_0001, "ltu_big");
    do_cmp(0, 4'd5, 32'h0, 32'h1234, "gez_zero");
    do_cmp(0, 4'd6, 32'h0, 32'h1234, "gtz_zero");
    do_cmp(0, 4'd7, 32'h8000_0000, 32'h0, "lez_min");
    do_cmp(0, 4'd8, 32'h7FFF_FFFF, 32'h0, "ltz_max");
    do_cmp(0, 4'd12, 32'h5, 32'h5, "mode12");

    // Start during RUN is ignored
    sel16 = 0;
    @(negedge clk);
    drive(0, 1'b1, 4'd0, 32'hCAFE_0000, 32'hCAFE_0000);
    @(negedge clk);
    drive(0, 1'b0, 4'd0, 32'hCAFE_0000, 32'hCAFE_0000);
    repeat (2) @(negedge clk);
    drive(0, 1'b1, 4'd0, 32'h0000_0001, 32'hCAFE_0000);
    @(negedge clk);
    drive(0, 1'b0, 4'd0, 32'h0000_0001, 32'hCAFE_0000);
    wait_done(n, bc);
    check("busystart_latency", n + 3, 8);
    check("busystart_cmp", cmp32, 1);
    @(negedge clk);
    check("busystart_no_rerun", busy32, 0);

    // Back-to-back: start in the DONE cycle
    @(negedge clk);
    drive(0, 1'b1, 4'd0, 32'h1111_2222, 32'h1111_2222);
    @(negedge clk);
    drive(0, 1'b0, 4'd0, 32'h1111_2222, 32'h1111_2222);
    wait_done(n, bc);
    check("b2b_first_cmp", cmp32, 1);
    drive(0, 1'b1, 4'd1, 32'h1111_2222, 32'h1111_2222);
    @(negedge clk);
    drive(0, 1'b0, 4'd1, 32'h1111_2222, 32'h1111_2222);
    check("b2b_accept_busy", busy32, 1);
    wait_done(n, bc);
    check("b2b_second_latency", n, 8);
    check("b2b_second_cmp", cmp32, 0);

    // Flush at RUN cycle 3 with simultaneous start
    do_cmp(0, 4'd0, 32'hABCD, 32'hABCD, "preflush");
    @(negedge clk);
    drive(0, 1'b1, 4'd0, 32'h1, 32'h2);
    @(negedge clk);
    drive(0, 1'b0, 4'd0, 32'h1, 32'h2);
    repeat (2) @(negedge clk);
    flush32 = 1'b1;
    drive(0, 1'b1, 4'd0, 32'h1, 32'h2);
    @(negedge clk);
    flush32 = 1'b0;
    drive(0, 1'b0, 4'd0, 32'h1, 32'h2);
    check("flush_busy", busy32, 0);
    check("flush_done", done32, 0);
    seen = 0;
    repeat (12) begin
      seen += int'(done32 | busy32);
      @(negedge clk);
    end
    check("flush_no_done", seen, 0);
    check("flush_cmp_kept", cmp32, 1);

    // Asynchronous reset mid-RUN
    do_cmp(0, 4'd1, 32'h1, 32'h2, "prereset");
    @(negedge clk);
    drive(0, 1'b1, 4'd0, 32'h77, 32'h77);
    @(negedge clk);
    drive(0, 1'b0, 4'd0, 32'h77, 32'h77);
    @(negedge clk);
    #3 reset = 1'b0;
    #1;
    check("arst_busy", busy32, 0);
    check("arst_done", done32, 0);
    check("arst_cmp",  cmp32,  0);
    @(posedge clk);
    #2 reset = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      seen += int'(done32);
    end
    check("arst_no_done", seen, 0);

    // Directed 16/8
    do_cmp(1, 4'd0, 32'h0000_BEEF, 32'h0000_BEEF, "w16_eq");
    do_cmp(1, 4'd0, 32'h0000_BEEF, 32'h0000_BEEE, "w16_eqdiff");
    do_cmp(1, 4'd2, 32'h0000_8001, 32'h0, "w16_pal");
    do_cmp(1, 4'd2, 32'h0000_8002, 32'h0, "w16_notpal");
    do_cmp(1, 4'd3, 32'h0000_FFFF, 32'h0000_0001, "w16_lt");

    // Randomized against the reference model
    for (int i = 0; i < 60; i++) begin
      rs = (i % 3 == 0);
      rm = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 3))
        0: rb = ra;
        1: begin
          for (int j = 0; j < (rs ? 8 : 16); j++) ra[(rs ? 15 : 31) - j] = ra[j];
        end
        2: ra = 32'h0;
        default: ;
      endcase
      do_cmp(rs, rm, ra, rb, $sformatf("rnd%0d_m%0d", i, rm));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/iter_cmp.md
ITER_CMP -- requirements
Module: iter_cmp

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits.
REQ-002 SHALL have parameter CHUNK, default 4, bits examined per cycle; WIDTH % CHUNK == 0 and CHUNK >= 1 are required; LAT = WIDTH/CHUNK.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request a comparison; sampled on a rising edge.
REQ-006 SHALL have port flush  input  1  synchronous abort of any in-flight comparison.
REQ-007 SHALL have port CMPMode  input  4  comparison mode, latched at accept.
REQ-008 SHALL have port A  input  WIDTH  first operand, latched at accept.
REQ-009 SHALL have port B  input  WIDTH  second operand, latched at accept.
REQ-010 SHALL have port busy  output  1  high while a comparison is running.
REQ-011 SHALL have port done  output  1  one-cycle pulse marking cmp valid.
REQ-012 SHALL have port cmp  output  1  result, held from done until the next done.

Function
REQ-013 SHALL implement states IDLE, RUN, DONE; IDLE->RUN on accepted start, RUN->DONE after LAT chunk cycles, DONE->IDLE unless start accepted (DONE->RUN).
REQ-014 SHALL accept start only in IDLE or DONE; start during RUN is ignored, with no effect on latched operands.
REQ-015 SHALL, for a start accepted at edge k, hold busy=1 for exactly LAT cycles and assert done=1 for the single cycle after edge k+LAT (32/4: start-to-done 8 edges).
REQ-016 SHALL use fixed latency LAT for every mode, with no early termination.
REQ-017 SHALL encode modes: EQUAL 0 (A==B), NOTEQUAL 1 (A!=B), PAL 2 (A[i]==A[WIDTH-1-i] for all i), LT 3 (signed A<B), LTU 4 (unsigned A<B), GEZ 5, GTZ 6, LEZ 7, LTZ 8 (signed A against zero, B ignored).
REQ-018 SHALL return cmp=0 with normal timing for modes 9-15.
REQ-019 SHALL, for magnitude modes, scan chunks MSB-first, tracking equal-so-far and less-than flags, with the operand MSBs inverted for signed modes.
REQ-020 SHALL, for PAL, compare one chunk of A against the bit-reversed mirror chunk each cycle.
REQ-021 SHALL, when flush is high on an edge, enter IDLE, drop busy, suppress done and leave cmp unchanged; flush dominates a simultaneous start.
REQ-022 SHALL keep cmp unchanged throughout RUN and update it only on entry to DONE.

Reset
REQ-023 SHALL, while reset is low, force state IDLE, busy=0, done=0, cmp=0 and clear latched operands, independent of clk.
REQ-024 SHALL discard an in-flight comparison on mid-RUN reset and emit no done after release.
REQ-025 SHALL accept start on the first rising edge after reset deasserts.

Structure
REQ-026 SHALL take its CMPMode encodings from the shared header name.v as CMPMode_* macros, extending the existing EQUAL/NOTEQUAL set without renumbering.
REQ-027 SHALL instantiate one sub-module cmp_slice, a combinational CHUNK-bit step (eq/lt update and mirror compare), once.
REQ-028 SHALL keep chunk counter width $clog2(LAT+1), reaching LAT without wrap.

Verification
REQ-029 SHALL cover EQUAL: A=B=32'h1234_5678, start -> busy 8 cycles, done pulse, cmp=1; repeat with B=32'h1234_5679 -> cmp=0.
REQ-030 SHALL cover PAL: A=32'h8000_0001 -> cmp=1; A=32'h8000_0002 -> cmp=0; A=32'hF00F_F00F -> cmp=1.
REQ-031 SHALL cover signed/unsigned: A=32'hFFFF_FFFF, B=32'h0000_0001 -> LT cmp=1, LTU cmp=0; GEZ with A=0 -> cmp=1; GTZ with A=0 -> cmp=0.
REQ-032 SHALL cover busy-start and back-to-back: start mid-RUN with different A -> ignored, first result unchanged; start in the DONE cycle -> accepted, second done exactly 8 edges later.
REQ-033 SHALL cover flush: flush at RUN cycle 3 with simultaneous start -> IDLE, no done, cmp keeps previous value.
REQ-034 SHALL cover reset: reset low mid-RUN, asynchronous to clk -> busy/done/cmp 0 immediately, no done after release; repeat EQUAL and PAL with WIDTH=16, CHUNK=8 (LAT=2).
